// File: rtl/dds_nco_bank_if.sv
// ---------------------------------------------------------------------------
// dds_nco_bank_if
// Bus bundle for the NCO bank: run control, configuration writes and the
// per-channel sample outputs. clk and rst_n stay plain ports on the design.
//
// Signals (direction shown from the slave / NCO bank side):
//   ena          in   global advance enable
//   div          in   tick period minus one, in clocks
//   cfg_we       in   configuration write strobe
//   cfg_ch       in   target channel
//   cfg_sel      in   0 freq, 1 mode, 2 phase, 3 reserved
//   cfg_data     in   write data (mode uses bits [1:0])
//   samples      out  8 bits per channel, channel k at [8k+7:8k]
//   sample_valid out  one-cycle pulse per channel update
//   sample_ch    out  channel updated with the current sample_valid
//   mix          out  average of all samples      (only with DDS_MIX_EN)
//   mix_valid    out  one-cycle pulse for mix      (only with DDS_MIX_EN)
// ---------------------------------------------------------------------------
interface dds_nco_bank_if #(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 16,
    parameter int DIV_W   = 8
);
    logic                 ena;
    logic [DIV_W-1:0]     div;
    logic                 cfg_we;
    logic [2:0]           cfg_ch;
    logic [1:0]           cfg_sel;
    logic [PHASE_W-1:0]   cfg_data;
    logic [8*NUM_CH-1:0]  samples;
    logic                 sample_valid;
    logic [2:0]           sample_ch;
`ifdef DDS_MIX_EN
    logic [7:0]           mix;
    logic                 mix_valid;
`endif

    modport slave (
        input  ena, div, cfg_we, cfg_ch, cfg_sel, cfg_data,
        output samples, sample_valid, sample_ch
`ifdef DDS_MIX_EN
        , output mix, mix_valid
`endif
    );

    modport master (
        output ena, div, cfg_we, cfg_ch, cfg_sel, cfg_data,
        input  samples, sample_valid, sample_ch
`ifdef DDS_MIX_EN
        , input mix, mix_valid
`endif
    );
endinterface

// File: rtl/dds_nco_bank.sv
// ---------------------------------------------------------------------------
// dds_nco_bank
// Bank of NUM_CH phase-accumulator NCOs sharing one prescaler tick and one
// waveform lookup unit. Each tick advances every accumulator, then a scan
// walks channels 0..NUM_CH-1 one per clock, registering each channel's
// 8-bit sample (sine / square / saw / triangle selected per channel).
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    dds_nco_bank_if.slave (control, config writes, sample outputs)
//
// Optional feature: define DDS_MIX_EN to add bus.mix / bus.mix_valid, the
// average of all channel samples registered after each complete scan.
// ---------------------------------------------------------------------------
module dds_nco_bank #(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 16,
    parameter int DIV_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    dds_nco_bank_if.slave   bus
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    // Quarter-wave magnitudes: floor(127.5*sin(2*pi*(i+0.5)/256)). The half
    // step offset makes the mirrored quadrants meet symmetrically.
    localparam logic [6:0] SINE_Q [64] = '{
          1,   4,   7,  10,  14,  17,  20,  23,
         26,  29,  32,  35,  38,  41,  44,  47,
         50,  53,  55,  58,  61,  64,  66,  69,
         72,  74,  77,  79,  82,  84,  86,  89,
         91,  93,  95,  97,  99, 101, 103, 105,
        106, 108, 110, 111, 113, 114, 115, 117,
        118, 119, 120, 121, 122, 123, 124, 124,
        125, 125, 126, 126, 127, 127, 127, 127
    };

    typedef enum logic {S_IDLE, S_SCAN} scan_state_t;

    logic [DIV_W-1:0]    presc_q;
    logic                tick;
    logic [7:0]          ch_p [NUM_CH];
    logic [1:0]          ch_m [NUM_CH];
    scan_state_t         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [8*NUM_CH-1:0] samples_q;
    logic                valid_q;
    logic [2:0]          ch_q;
    logic [7:0]          wave;

    function automatic logic [7:0] wave_f(input logic [1:0] mode, input logic [7:0] p);
        logic [5:0] addr;
        logic [6:0] mag;
        logic [7:0] res;
        addr = p[6] ? ~p[5:0] : p[5:0];
        mag  = SINE_Q[addr];
        case (mode)
            2'd0:    res = p[7] ? (8'd127 - {1'b0, mag}) : (8'd128 + {1'b0, mag});
            2'd1:    res = p[7] ? 8'd0 : 8'd255;
            2'd2:    res = p;
            default: res = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
        endcase
        return res;
    endfunction

    assign tick = bus.ena && (presc_q == bus.div);

    // Prescaler freezes while ena is low so the tick phase is preserved.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (bus.ena) begin
            presc_q <= (presc_q == bus.div) ? '0 : presc_q + DIV_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [PHASE_W-1:0] freq_q;
            logic [PHASE_W-1:0] phase_q;
            logic [1:0]         mode_q;
            logic               hit;

            // cfg_ch values >= NUM_CH never match any generated channel.
            assign hit = bus.cfg_we && (bus.cfg_ch == 3'(gi));

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    freq_q  <= '0;
                    phase_q <= '0;
                    mode_q  <= '0;
                end else begin
                    if (hit && bus.cfg_sel == 2'd0) freq_q <= bus.cfg_data;
                    if (hit && bus.cfg_sel == 2'd1) mode_q <= bus.cfg_data[1:0];
                    // A phase write takes priority over the tick accumulate.
                    if (hit && bus.cfg_sel == 2'd2) begin
                        phase_q <= bus.cfg_data;
                    end else if (tick) begin
                        phase_q <= phase_q + freq_q;
                    end
                end
            end

            assign ch_p[gi] = phase_q[PHASE_W-1 -: 8];
            assign ch_m[gi] = mode_q;
        end
    endgenerate

    // Scan sequencer: a tick (re)starts at channel 0, even mid-scan; a scan
    // in progress runs to completion regardless of ena.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (tick) begin
            state_d = S_SCAN;
            idx_d   = '0;
        end else if (state_q == S_SCAN) begin
            if (idx_q == LAST_IDX) begin
                state_d = S_IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    assign wave = wave_f(ch_m[idx_q], ch_p[idx_q]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samples_q <= '0;
            valid_q   <= 1'b0;
            ch_q      <= '0;
        end else begin
            valid_q <= (state_q == S_SCAN);
            if (state_q == S_SCAN) begin
                samples_q[{idx_q, 3'b000} +: 8] <= wave;
                ch_q                            <= 3'(idx_q);
            end
        end
    end

    assign bus.samples      = samples_q;
    assign bus.sample_valid = valid_q;
    assign bus.sample_ch    = ch_q;

`ifdef DDS_MIX_EN
    localparam int SUM_W = IDX_W + 8;

    logic [SUM_W-1:0] mix_sum;
    logic [7:0]       mix_q;
    logic             mix_valid_q;

    always_comb begin
        mix_sum = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            mix_sum = mix_sum + SUM_W'(samples_q[8*k +: 8]);
        end
    end

    // NUM_CH is a power of two, so the top 8 bits of the sum are the mean.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
        end else begin
            mix_valid_q <= valid_q && (ch_q == 3'(NUM_CH - 1));
            if (valid_q && (ch_q == 3'(NUM_CH - 1))) begin
                mix_q <= mix_sum[SUM_W-1 -: 8];
            end
        end
    end

    assign bus.mix       = mix_q;
    assign bus.mix_valid = mix_valid_q;
`endif
endmodule

// File: tb/tb_dds_nco_bank.sv
module tb_dds_nco_bank;
    localparam int NUM_CH  = 4;
    localparam int PHASE_W = 16;
    localparam int DIV_W   = 8;
    localparam real PI     = 3.14159265358979;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dds_nco_bank_if #(.NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .DIV_W(DIV_W)) bus ();

    dds_nco_bank #(.NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural reference ----------------
    // Expected waveform straight from the formula: sine evaluated at the
    // centre of each 1/256 phase bin, magnitude truncated, split around 127.5.
    function automatic int ref_wave(input int mode, input int p);
        real s, a;
        int  mag;
        case (mode)
            0: begin
                s   = $sin(2.0 * PI * (real'(p) + 0.5) / 256.0);
                a   = (s < 0.0) ? -s : s;
                mag = $rtoi(127.5 * a);
                return (s > 0.0) ? 128 + mag : 127 - mag;
            end
            1:       return (p >= 128) ? 0 : 255;
            2:       return p;
            default: return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
        endcase
    endfunction

    int     m_presc;
    int     m_freq  [NUM_CH];
    int     m_phase [NUM_CH];
    int     m_mode  [NUM_CH];
    int     m_samp  [NUM_CH];
    longint m_due   [NUM_CH];  // cycle in which channel k is looked up, -1 none
    longint m_cyc = 0;
    bit     m_valid;
    int     m_ch;
    int     m_mix;
    bit     m_mix_valid;
    bit     m_tick;
    bit     m_upd;
    int     m_sum;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_presc = 0; m_valid = 0; m_ch = 0; m_mix = 0; m_mix_valid = 0;
                for (int k = 0; k < NUM_CH; k++) begin
                    m_freq[k] = 0; m_phase[k] = 0; m_mode[k] = 0;
                    m_samp[k] = 0; m_due[k] = -1;
                end
            end else begin
                m_tick = bus.ena && (m_presc == int'(bus.div));
                m_mix_valid = m_valid && (m_ch == NUM_CH - 1);
                if (m_mix_valid) begin
                    m_sum = 0;
                    for (int k = 0; k < NUM_CH; k++) m_sum += m_samp[k];
                    m_mix = m_sum / NUM_CH;
                end
                m_upd = 0;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (m_due[k] == m_cyc) begin
                        m_samp[k] = ref_wave(m_mode[k], m_phase[k] >> (PHASE_W - 8));
                        m_ch = k; m_upd = 1; m_due[k] = -1;
                    end
                end
                m_valid = m_upd;
                if (m_tick) begin
                    for (int k = 0; k < NUM_CH; k++)
                        m_phase[k] = (m_phase[k] + m_freq[k]) % (1 << PHASE_W);
                end
                if (bus.cfg_we && int'(bus.cfg_ch) < NUM_CH) begin
                    case (bus.cfg_sel)
                        2'd0: m_freq[bus.cfg_ch]  = int'(bus.cfg_data);
                        2'd1: m_mode[bus.cfg_ch]  = int'(bus.cfg_data) & 3;
                        2'd2: m_phase[bus.cfg_ch] = int'(bus.cfg_data);
                        default: ;
                    endcase
                end
                if (m_tick) begin
                    for (int k = 0; k < NUM_CH; k++) m_due[k] = m_cyc + 1 + k;
                end
                if (bus.ena)
                    m_presc = (m_presc == int'(bus.div)) ? 0 : (m_presc + 1) % (1 << DIV_W);
            end
            m_cyc++;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and compare every DUT output against the model.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < NUM_CH; k++)
            chk($sformatf("samples_ch%0d", k), 32'(bus.samples[8*k +: 8]), m_samp[k]);
        chk("sample_valid", 32'(bus.sample_valid), 32'(m_valid));
        if (m_valid) chk("sample_ch", 32'(bus.sample_ch), m_ch);
`ifdef DDS_MIX_EN
        chk("mix_valid", 32'(bus.mix_valid), 32'(m_mix_valid));
        chk("mix", 32'(bus.mix), m_mix);
`endif
    endtask

    task automatic cfg(input int ch, input int sel, input int data);
        bus.cfg_we = 1'b1; bus.cfg_ch = 3'(ch); bus.cfg_sel = 2'(sel);
        bus.cfg_data = PHASE_W'(data);
        $display("cfg write ch=%0d sel=%0d data=0x%0h", ch, sel, data);
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bus.ena = 1'b0; bus.cfg_we = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic wait_ch(input string name, input int ch, input int budget);
        int n = 0;
        while (!(bus.sample_valid && int'(bus.sample_ch) == ch) && n < budget) begin
            step(); n++;
        end
        chk({name, "_wait"}, 32'(bus.sample_valid && int'(bus.sample_ch) == ch), 1);
    endtask

    int prev, cnt, lane;
    int cnt_ch [NUM_CH];

    initial begin
        bus.ena = 1'b0; bus.div = '0; bus.cfg_we = 1'b0; bus.cfg_ch = '0;
        bus.cfg_sel = '0; bus.cfg_data = '0;
        repeat (3) step();
        chk("rst_samples", 32'(bus.samples), 0);
        chk("rst_valid", 32'(bus.sample_valid), 0);

        // Quarter-turn sine on ch0, div=3.
        rst_n = 1'b1;
        cfg(0, 0, 'h4000);
        bus.div = 3; bus.ena = 1'b1;
        wait_ch("A", 0, 20);
        chk("A_s0", 32'(bus.samples[7:0]), 255);
        for (int k = 1; k < NUM_CH; k++) begin
            step();
            chk($sformatf("A_valid%0d", k), 32'(bus.sample_valid), 1);
            chk($sformatf("A_ch%0d", k), 32'(bus.sample_ch), k);
            chk($sformatf("A_s%0d", k), 32'(bus.samples[8*k +: 8]), 129);
        end
        $display("scenario A done");

        // Sawtooth on ch1 steps by one per tick and wraps.
        do_reset();
        cfg(1, 1, 2); cfg(1, 0, 'h0100);
        bus.div = 3; bus.ena = 1'b1;
        prev = 0; cnt = 0;
        for (int n = 0; n < 1200 && cnt < 260; n++) begin
            step();
            if (bus.sample_valid && bus.sample_ch == 3'd1) begin
                lane = int'(bus.samples[15:8]);
                if (cnt == 0) chk("B_first", lane, 1);
                else          chk("B_inc", lane, (prev + 1) % 256);
                prev = lane; cnt++;
            end
        end
        chk("B_count", cnt, 260);

        // div=0: tick every clock, only ch0 ever completes.
        do_reset();
        cfg(0, 1, 2); cfg(0, 0, 'h0100);
        bus.div = 0; bus.ena = 1'b1;
        wait_ch("B0", 0, 10);
        prev = int'(bus.samples[7:0]);
        chk("B0_first", prev, 1);
        repeat (20) begin
            step();
            chk("B0_ch", 32'(bus.sample_ch), 0);
            chk("B0_inc", 32'(bus.samples[7:0]), (prev + 1) % 256);
            prev = int'(bus.samples[7:0]);
        end
        $display("scenario B done");

        // Phase write on ch2 in the tick cycle overrides the accumulate.
        do_reset();
        cfg(2, 0, 'h1000);
        bus.div = 3; bus.ena = 1'b1;
        cnt = 0;
        while (m_presc != 3 && cnt < 20) begin step(); cnt++; end
        chk("C_tick_found", 32'(m_presc), 3);
        cfg(2, 2, 'h8000);
        wait_ch("C", 2, 10);
        chk("C_s2", 32'(bus.samples[23:16]), 126);
        step();
        wait_ch("C2", 2, 10);
        chk("C_s2_next", 32'(bus.samples[23:16]), 77);
        $display("scenario C done");

        // div=1: scan restarts before channels 2 and 3 are reached.
        do_reset();
        bus.div = 1; bus.ena = 1'b1;
        for (int k = 0; k < NUM_CH; k++) cnt_ch[k] = 0;
        repeat (40) begin
            step();
            if (bus.sample_valid) cnt_ch[bus.sample_ch[1:0]]++;
        end
        chk("D_ch0_seen", 32'(cnt_ch[0] > 0), 1);
        chk("D_ch1_seen", 32'(cnt_ch[1] > 0), 1);
        chk("D_ch2_none", cnt_ch[2], 0);
        chk("D_ch3_none", cnt_ch[3], 0);
        $display("scenario D done");

        // Reset in the middle of a scan.
        do_reset();
        cfg(0, 0, 'h4000);
        bus.div = 3; bus.ena = 1'b1;
        wait_ch("E", 0, 20);
        rst_n = 1'b0;
        step();
        chk("E_samples0", 32'(bus.samples), 0);
        chk("E_valid0", 32'(bus.sample_valid), 0);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            chk($sformatf("E_quiet%0d", n), 32'(bus.sample_valid), 0);
        end
        step();
        chk("E_first_valid", 32'(bus.sample_valid), 1);
        $display("scenario E done");

`ifdef DDS_MIX_EN
        // Two full-scale squares and two zero squares average to 127.
        do_reset();
        for (int k = 0; k < NUM_CH; k++) cfg(k, 1, 1);
        cfg(2, 2, 'h8000); cfg(3, 2, 'h8000);
        bus.div = 3; bus.ena = 1'b1;
        wait_ch("F", 3, 20);
        chk("F_mixv_early", 32'(bus.mix_valid), 0);
        step();
        chk("F_mixv", 32'(bus.mix_valid), 1);
        chk("F_mix", 32'(bus.mix), 127);
        $display("scenario F done");
`endif

        // Randomised traffic against the model.
        do_reset();
        bus.div = 2;
        for (int n = 0; n < 3000; n++) begin
            bus.ena      = ($urandom_range(0, 9) != 0);
            bus.cfg_we   = ($urandom_range(0, 3) == 0);
            bus.cfg_ch   = 3'($urandom_range(0, 7));
            bus.cfg_sel  = 2'($urandom_range(0, 3));
            bus.cfg_data = PHASE_W'($urandom);
            if ($urandom_range(0, 199) == 0) bus.div = DIV_W'($urandom_range(0, 5));
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1; bus.cfg_we = 1'b0;
        step();
        $display("random phase done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
